mmio_bus_arbiter: RTL and testbench

//  Shares the single FPro MMIO bus (mmio_cs/wr/rd/addr/wr_data/rd_data) between two masters:
//  M0 (CPU bridge) and M1 (hardware sequencer / DMA). The MMIO slot controller sits downstream.

---
 rtl/mmio_arb_pkg.sv | 22 ++
 rtl/mmio_bus_arbiter.sv | 134 +++++++++++++
 tb/tb_mmio_bus_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_arb_pkg.sv
// Shared types and helpers for the two-master MMIO bus arbiter.
package mmio_arb_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 21;
  localparam int unsigned DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } state_e;

  // Winner index for the current request vector. Only meaningful when req != 0.
  function automatic logic rr_pick(input logic [1:0] req, input logic last, input logic fixed);
    if (req == 2'b11) begin
      return fixed ? 1'b0 : ~last;
    end
    return req[1];
  endfunction

endpackage

// File: rtl/mmio_bus_arbiter.sv
// Two-master arbiter for the FPro MMIO bus: one strobe cycle per grant, optional read
// wait cycles, then a one-cycle ack carrying the registered read data.
module mmio_bus_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W    = DATA_W_DEFAULT,
  parameter int unsigned RD_LAT    = 0,
  parameter bit          FIXED_PRI = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        m_req,
  input  logic [1:0]        m_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic [1:0]        m_ack,
  output logic [DATA_W-1:0] m_rd_data,
  output logic              mmio_cs,
  output logic              mmio_wr,
  output logic              mmio_rd,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [DATA_W-1:0] mmio_wr_data,
  input  logic [DATA_W-1:0] mmio_rd_data
);

  // Counter keeps one bit even when there are no wait cycles so the logic stays uniform.
  localparam int unsigned      CNT_W    = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                winner_q, winner_d;
  logic                cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

  // Next-state: arbitrate in IDLE, latch the winner's command, sequence strobe/wait/ack.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    cmd_wr_d     = cmd_wr_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    rd_data_d    = rd_data_q;
    wait_cnt_d   = wait_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|m_req) begin
          winner_d     = rr_pick(m_req, last_grant_q, FIXED_PRI);
          last_grant_d = winner_d;
          cmd_wr_d     = m_wr[winner_d];
          cmd_addr_d   = winner_d ? m1_addr : m0_addr;
          cmd_wdata_d  = winner_d ? m1_wr_data : m0_wr_data;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        wait_cnt_d = '0;
        if (cmd_wr_q) begin
          state_d = ACK;
        end else if (RD_LAT == 0) begin
          rd_data_d = mmio_rd_data;
          state_d   = ACK;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt_q == LAST_CNT) begin
          rd_data_d = mmio_rd_data;
          state_d   = ACK;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and command registers; last_grant resets to M1 so M0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      cmd_wr_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      rd_data_q    <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      cmd_wr_q     <= cmd_wr_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      rd_data_q    <= rd_data_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  // Outputs decode from registered state, so reset clears strobes and ack immediately.
  always_comb begin
    m_ack   = '0;
    mmio_cs = 1'b0;
    mmio_wr = 1'b0;
    mmio_rd = 1'b0;
    if (state_q == ISSUE) begin
      mmio_cs = 1'b1;
      mmio_wr = cmd_wr_q;
      mmio_rd = ~cmd_wr_q;
    end
    if (state_q == ACK) begin
      m_ack[winner_q] = 1'b1;
    end
  end

  assign mmio_addr    = cmd_addr_q;
  assign mmio_wr_data = cmd_wdata_q;
  assign m_rd_data    = rd_data_q;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Bench for mmio_bus_arbiter: three configurations (round-robin, fixed priority, RD_LAT=2)
// share one set of master/bus inputs; each test observes one of them via sel.
module tb_mmio_bus_arbiter;

  localparam int NC = 300;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  m_req, m_wr;
  logic [20:0] m0_addr, m1_addr;
  logic [31:0] m0_wr_data, m1_wr_data, mmio_rd_data;

  logic [1:0]  ack_a [3];
  logic [31:0] rdd_a [3];
  logic        cs_a [3];
  logic        wr_a [3];
  logic        rd_a [3];
  logic [20:0] addr_a [3];
  logic [31:0] wd_a [3];

  int n_cmp = 0;
  int n_err = 0;
  int sel = 0;

  // Schedule of expected outputs, filled when the model decides a grant.
  logic        e_cs [NC+8];
  logic        e_wr [NC+8];
  logic        e_rd [NC+8];
  logic [1:0]  e_ack [NC+8];
  logic [20:0] e_addr [NC+8];
  logic [31:0] e_wd [NC+8];
  logic [31:0] e_rdata [NC+8];
  logic [31:0] rd_hist [NC+8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mmio_bus_arbiter #(
      .ADDR_W   (21),
      .DATA_W   (32),
      .RD_LAT   ((g == 2) ? 2 : 0),
      .FIXED_PRI(g == 1)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .m_req       (m_req),
      .m_wr        (m_wr),
      .m0_addr     (m0_addr),
      .m1_addr     (m1_addr),
      .m0_wr_data  (m0_wr_data),
      .m1_wr_data  (m1_wr_data),
      .m_ack       (ack_a[g]),
      .m_rd_data   (rdd_a[g]),
      .mmio_cs     (cs_a[g]),
      .mmio_wr     (wr_a[g]),
      .mmio_rd     (rd_a[g]),
      .mmio_addr   (addr_a[g]),
      .mmio_wr_data(wd_a[g]),
      .mmio_rd_data(mmio_rd_data)
    );
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    reset        = 1'b0;
    m_req        = '0;
    m_wr         = '0;
    m0_addr      = '0;
    m1_addr      = '0;
    m0_wr_data   = '0;
    m1_wr_data   = '0;
    mmio_rd_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic new_cmd(input int i);
    m_wr[i] = 1'($urandom_range(0, 1));
    if (i == 0) begin
      m0_addr    = 21'($urandom);
      m0_wr_data = $urandom;
    end else begin
      m1_addr    = 21'($urandom);
      m1_wr_data = $urandom;
    end
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    m_req        = 2'b11;
    m_wr         = 2'b01;
    m0_addr      = 21'h1ABCD;
    m1_addr      = 21'h0F0F0;
    mmio_rd_data = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if ({ack_a[d], rdd_a[d], cs_a[d], wr_a[d], rd_a[d], addr_a[d], wd_a[d]} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs dut%0d: got ack=%b cs=%b wr=%b rd=%b addr=%h wd=%h rdd=%h want all 0",
                 d, ack_a[d], cs_a[d], wr_a[d], rd_a[d], addr_a[d], wd_a[d], rdd_a[d]);
      end
    end
    do_reset();
  endtask

  task automatic test_write();
    sel = 0;
    do_reset();
    m_req = 2'b01; m_wr = 2'b01; m0_addr = 21'h00C04; m0_wr_data = 32'h0000_00A5;
    @(negedge clk);
    n_cmp++;
    if ({cs_a[0], wr_a[0], rd_a[0], ack_a[0], addr_a[0], wd_a[0]} !==
        {1'b1, 1'b1, 1'b0, 2'b00, 21'h00C04, 32'h0000_00A5}) begin
      n_err++;
      $display("FAIL write_strobe: got cs=%b wr=%b rd=%b ack=%b addr=%h wd=%h want 1 1 0 00 00c04 000000a5",
               cs_a[0], wr_a[0], rd_a[0], ack_a[0], addr_a[0], wd_a[0]);
    end
    @(negedge clk);
    n_cmp++;
    if ({ack_a[0], cs_a[0]} !== {2'b01, 1'b0}) begin
      n_err++;
      $display("FAIL write_ack: got ack=%b cs=%b want ack=01 cs=0", ack_a[0], cs_a[0]);
    end
    m_req = 2'b00;
  endtask

  task automatic test_read_m1();
    sel = 0;
    do_reset();
    m_req = 2'b10; m_wr = 2'b00; m1_addr = 21'h12345;
    @(negedge clk);
    mmio_rd_data = 32'hDEAD_BEEF;
    n_cmp++;
    if ({cs_a[0], wr_a[0], rd_a[0], addr_a[0]} !== {1'b1, 1'b0, 1'b1, 21'h12345}) begin
      n_err++;
      $display("FAIL read_strobe: got cs=%b wr=%b rd=%b addr=%h want 1 0 1 12345",
               cs_a[0], wr_a[0], rd_a[0], addr_a[0]);
    end
    @(negedge clk);
    mmio_rd_data = 32'h0BAD_0BAD;
    n_cmp++;
    if ({ack_a[0], rdd_a[0], wr_a[0]} !== {2'b10, 32'hDEAD_BEEF, 1'b0}) begin
      n_err++;
      $display("FAIL read_ack: got ack=%b rdd=%h wr=%b want 10 deadbeef 0",
               ack_a[0], rdd_a[0], wr_a[0]);
    end
    m_req = 2'b00;
  endtask

  task automatic test_round_robin();
    logic got;
    logic [1:0] want;
    sel = 0;
    reset = 1'b0;
    m_req = 2'b11; m_wr = 2'b11;
    m0_addr = 21'h00100; m1_addr = 21'h1F000;
    m0_wr_data = 32'h1111_0000; m1_wr_data = 32'h2222_0000;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      want = (n % 2 == 0) ? 2'b01 : 2'b10;
      got = 1'b0;
      for (int c = 0; c < 5 && !got; c++) begin
        @(negedge clk);
        got = cs_a[0];
      end
      n_cmp++;
      if (!got || addr_a[0] !== (want[1] ? 21'h1F000 : 21'h00100)) begin
        n_err++;
        $display("FAIL rr_strobe_addr n=%0d: got cs=%b addr=%h want cs=1 addr of master %b",
                 n, got, addr_a[0], want);
      end
      @(negedge clk);
      n_cmp++;
      if (ack_a[0] !== want) begin
        n_err++;
        $display("FAIL rr_ack_order n=%0d: got %b want %b", n, ack_a[0], want);
      end
    end
    m_req = 2'b00;
  endtask

  task automatic test_fixed_pri();
    logic got;
    sel = 1;
    reset = 1'b0;
    m_req = 2'b11; m_wr = 2'b11;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 5; n++) begin
      got = 1'b0;
      for (int c = 0; c < 5 && !got; c++) begin
        @(negedge clk);
        got = (ack_a[1] != 2'b00);
      end
      n_cmp++;
      if (!got || ack_a[1] !== ((n < 4) ? 2'b01 : 2'b10)) begin
        n_err++;
        $display("FAIL fixed_pri_ack n=%0d: got ack=%b (seen=%b) want %b",
                 n, ack_a[1], got, (n < 4) ? 2'b01 : 2'b10);
      end
      if (n == 3) m_req[0] = 1'b0;
    end
    m_req = 2'b00;
  endtask

  task automatic test_rd_lat();
    sel = 2;
    do_reset();
    m_req = 2'b01; m_wr = 2'b00; m0_addr = 21'h0ABCD;
    mmio_rd_data = 32'hAAAA_0001;
    @(negedge clk);
    mmio_rd_data = 32'hAAAA_0002;
    n_cmp++;
    if ({cs_a[2], rd_a[2], wr_a[2], ack_a[2], addr_a[2]} !== {3'b110, 2'b00, 21'h0ABCD}) begin
      n_err++;
      $display("FAIL lat_strobe: got cs=%b rd=%b wr=%b ack=%b addr=%h want 1 1 0 00 0abcd",
               cs_a[2], rd_a[2], wr_a[2], ack_a[2], addr_a[2]);
    end
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      mmio_rd_data = (w == 1) ? 32'h1234_5678 : 32'hAAAA_0003;
      n_cmp++;
      if ({cs_a[2], rd_a[2], ack_a[2], addr_a[2]} !== {2'b00, 2'b00, 21'h0ABCD}) begin
        n_err++;
        $display("FAIL lat_wait w=%0d: got cs=%b rd=%b ack=%b addr=%h want 0 0 00 0abcd",
                 w, cs_a[2], rd_a[2], ack_a[2], addr_a[2]);
      end
    end
    @(negedge clk);
    mmio_rd_data = 32'hAAAA_0004;
    n_cmp++;
    if ({ack_a[2], rdd_a[2]} !== {2'b01, 32'h1234_5678}) begin
      n_err++;
      $display("FAIL lat_read_ack: got ack=%b rdd=%h want 01 12345678", ack_a[2], rdd_a[2]);
    end
    m_wr = 2'b01; m0_wr_data = 32'h5A5A_5A5A;
    @(negedge clk);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ack_a[2], rdd_a[2]} !== {2'b01, 32'h1234_5678}) begin
      n_err++;
      $display("FAIL lat_write_ack: got ack=%b rdd=%h want 01 12345678 (ack at t+2)",
               ack_a[2], rdd_a[2]);
    end
    m_req = 2'b00;
  endtask

  task automatic test_reset_in_issue();
    logic bad;
    sel = 0;
    do_reset();
    m_req = 2'b01; m_wr = 2'b01; m0_addr = 21'h00777; m0_wr_data = 32'hCAFE_F00D;
    @(negedge clk);
    n_cmp++;
    if (cs_a[0] !== 1'b1) begin
      n_err++;
      $display("FAIL rst_issue_pre: got cs=%b want 1", cs_a[0]);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({cs_a[0], wr_a[0], rd_a[0], ack_a[0]} !== 5'b0) begin
      n_err++;
      $display("FAIL rst_issue_async: got cs=%b wr=%b rd=%b ack=%b want all 0",
               cs_a[0], wr_a[0], rd_a[0], ack_a[0]);
    end
    m_req = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ack_a[0] != 2'b00 || cs_a[0] != 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_err++;
      $display("FAIL rst_no_spurious: got activity=%b want 0", bad);
    end
    m_req = 2'b01;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ack_a[0], addr_a[0], wd_a[0]} !== {2'b01, 21'h00777, 32'hCAFE_F00D}) begin
      n_err++;
      $display("FAIL rst_reissue: got ack=%b addr=%h wd=%h want 01 00777 cafef00d",
               ack_a[0], addr_a[0], wd_a[0]);
    end
    m_req = 2'b00;
  endtask

  // Random masters against a transaction-schedule model of the arbitration rules.
  task automatic test_random(input int d, input int lat, input bit fixed);
    int free;
    int s, a, l;
    logic last, w;
    sel = d;
    for (int j = 0; j < NC + 8; j++) begin
      e_cs[j] = 1'b0; e_wr[j] = 1'b0; e_rd[j] = 1'b0; e_ack[j] = 2'b00;
      e_addr[j] = '0; e_wd[j] = '0; e_rdata[j] = '0;
      rd_hist[j] = $urandom;
    end
    free = 0;
    last = 1'b1;
    do_reset();
    for (int k = 0; k < NC; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if ({cs_a[d], wr_a[d], rd_a[d], ack_a[d]} !== {e_cs[k], e_wr[k], e_rd[k], e_ack[k]}) begin
        n_err++;
        $display("FAIL rand_ctl dut%0d cyc%0d: got cs/wr/rd/ack=%b want %b", d, k,
                 {cs_a[d], wr_a[d], rd_a[d], ack_a[d]}, {e_cs[k], e_wr[k], e_rd[k], e_ack[k]});
      end
      n_cmp++;
      if ({addr_a[d], wd_a[d]} !== {e_addr[k], e_wd[k]}) begin
        n_err++;
        $display("FAIL rand_bus dut%0d cyc%0d: got addr=%h wd=%h want addr=%h wd=%h", d, k,
                 addr_a[d], wd_a[d], e_addr[k], e_wd[k]);
      end
      n_cmp++;
      if (rdd_a[d] !== e_rdata[k]) begin
        n_err++;
        $display("FAIL rand_rdata dut%0d cyc%0d: got %h want %h", d, k, rdd_a[d], e_rdata[k]);
      end
      for (int i = 0; i < 2; i++) begin
        if (m_req[i] && e_ack[k][i]) begin
          if ($urandom_range(0, 1) == 0) m_req[i] = 1'b0;
          else new_cmd(i);
        end else if (!m_req[i] && $urandom_range(0, 2) == 0) begin
          m_req[i] = 1'b1;
          new_cmd(i);
        end
      end
      mmio_rd_data = rd_hist[k];
      if (k >= free && m_req != 2'b00) begin
        if (m_req == 2'b11) w = fixed ? 1'b0 : ~last;
        else w = m_req[1];
        last = w;
        s = k + 1;
        l = m_wr[w] ? 0 : lat;
        a = s + 1 + l;
        e_cs[s] = 1'b1;
        e_wr[s] = m_wr[w];
        e_rd[s] = ~m_wr[w];
        e_ack[a][w] = 1'b1;
        for (int j = s; j < NC + 8; j++) begin
          e_addr[j] = w ? m1_addr : m0_addr;
          e_wd[j]   = w ? m1_wr_data : m0_wr_data;
        end
        if (!m_wr[w]) begin
          for (int j = a; j < NC + 8; j++) e_rdata[j] = rd_hist[s + l];
        end
        free = a + 1;
      end
    end
    m_req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_m1();
    test_round_robin();
    test_fixed_pri();
    test_rd_lat();
    test_reset_in_issue();
    test_random(0, 0, 1'b0);
    test_random(1, 0, 1'b1);
    test_random(2, 2, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
